// File: rtl/half_sub_pkg.sv
// Shared definitions for the registered half subtractor and its bit slice.
// The bin port is added by defining HALF_SUB_BORROW_IN_EN.
package half_sub_pkg;

    // Classic 1-bit half subtractor unless overridden.
    localparam int DEFAULT_WIDTH = 1;

    // One ripple slice result: borrow-out and difference bit.
    typedef struct packed {
        logic bo;
        logic d;
    } slice_res_t;

    // Full-subtractor bit equations shared by every slice.
    function automatic slice_res_t sub_bit(input logic a, input logic b, input logic bin);
        slice_res_t r;
        r.d  = a ^ b ^ bin;
        r.bo = (~a & b) | (~(a ^ b) & bin);
        return r;
    endfunction

endpackage

// File: rtl/half_sub_sub_bit_slice.sv
// Purely combinational 1-bit subtractor slice: {bo, d} = a - b - bin.
// With bin tied low it degenerates to a half subtractor.
module sub_bit_slice
    import half_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    slice_res_t res;

    assign res = sub_bit(a, b, bin);
    assign d   = res.d;
    assign bo  = res.bo;

endmodule

// File: rtl/half_sub.sv
// Registered WIDTH-bit subtractor: {bout, diff} = a - b (- bin), one cycle
// latency, built from WIDTH ripple slices with the result registered after
// the full ripple. Define HALF_SUB_BORROW_IN_EN to add the bin input.
module half_sub
    import half_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef HALF_SUB_BORROW_IN_EN
    input  logic             bin,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef struct packed {
        logic             borrow;
        logic [WIDTH-1:0] diff;
    } result_t;

    logic [WIDTH:0]   brw;
    logic [WIDTH-1:0] d_comb;
    result_t          res_d;
    result_t          res_q;

`ifdef HALF_SUB_BORROW_IN_EN
    assign brw[0] = bin;
`else
    // Slice 0 sees no borrow-in, so it acts as a plain half subtractor.
    assign brw[0] = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        sub_bit_slice u_slice (
            .a   (a[i]),
            .b   (b[i]),
            .bin (brw[i]),
            .d   (d_comb[i]),
            .bo  (brw[i+1])
        );
    end

    assign res_d.borrow = brw[WIDTH];
    assign res_d.diff   = d_comb;

    // Output register; reset clears immediately and drops any pending result.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;
    end

    assign diff = res_q.diff;
    assign bout = res_q.borrow;

endmodule

// File: tb/tb_half_sub.sv
// Self-checking bench for half_sub: WIDTH=1 and WIDTH=8 instances driven
// side by side, compared against an integer-arithmetic reference model.
// Honours HALF_SUB_BORROW_IN_EN to exercise the bin input.
module tb_half_sub;

    logic       clock;
    logic       rst_n;
    logic       a1, b1, bin1;
    logic [7:0] a8, b8;
    logic       bin8;
    logic       diff1, bout1;
    logic [7:0] diff8;
    logic       bout8;

    int n_cmp  = 0;
    int n_fail = 0;

    half_sub #(.WIDTH(1)) u_dut1 (
        .clock (clock),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
`ifdef HALF_SUB_BORROW_IN_EN
        .bin   (bin1),
`endif
        .diff  (diff1),
        .bout  (bout1)
    );

    half_sub #(.WIDTH(8)) u_dut8 (
        .clock (clock),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
`ifdef HALF_SUB_BORROW_IN_EN
        .bin   (bin8),
`endif
        .diff  (diff8),
        .bout  (bout8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference: plain signed subtraction, then wrap into w bits.
    function automatic void model(input int w, input int av, input int bv, input int binv,
                                  output int d, output logic bo);
        int r;
        r  = av - bv - binv;
        bo = (r < 0);
        if (r < 0) r = r + (1 << w);
        d  = r;
    endfunction

    // Borrow-in only exists in the extended build; otherwise it is zero.
    function automatic int eff_bin(input logic v);
`ifdef HALF_SUB_BORROW_IN_EN
        return int'(v);
`else
        return 0 * int'(v);
`endif
    endfunction

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; bin1 = 1'b0;
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
        #1;
        n_cmp++;
        if ({bout1, diff1, bout8, diff8} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_assert got %h want 000", {bout1, diff1, bout8, diff8});
        end
        for (int i = 0; i < 3; i++) begin
            after_edge();
            n_cmp++;
            if ({bout1, diff1, bout8, diff8} !== 10'h000) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] got %h want 000", i, {bout1, diff1, bout8, diff8});
            end
            @(negedge clock);
            n_cmp++;
            if ({bout1, diff1, bout8, diff8} !== 10'h000) begin
                n_fail++;
                $display("FAIL reset_hold_mid[%0d] got %h want 000", i, {bout1, diff1, bout8, diff8});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [1:0] vecs [4];
        int   d;
        logic bo;
        vecs[0] = 2'b01; vecs[1] = 2'b00; vecs[2] = 2'b11; vecs[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a1 = vecs[i][1]; b1 = vecs[i][0]; bin1 = 1'b0;
            model(1, int'(a1), int'(b1), 0, d, bo);
            for (int c = 0; c < 2; c++) begin
                after_edge();
                n_cmp++;
                if ({bout1, diff1} !== {bo, d[0]}) begin
                    n_fail++;
                    $display("FAIL truth a=%b b=%b cyc%0d got %b%b want %b%b",
                             a1, b1, c, bout1, diff1, bo, d[0]);
                end
            end
        end
    endtask

    task automatic test_latency();
        int   d;
        logic bo;
        @(negedge clock);
        a1 = 1'b1; b1 = 1'b0; a8 = 8'h10; b8 = 8'h01; bin1 = 1'b0; bin8 = 1'b0;
        after_edge();
        // Change right after the edge; outputs must hold the old result.
        a1 = 1'b0; b1 = 1'b1; a8 = 8'h01; b8 = 8'h10;
        for (int t = 0; t < 3; t++) begin
            n_cmp++;
            if ({bout1, diff1, bout8, diff8} !== {2'b01, 1'b0, 8'h0F}) begin
                n_fail++;
                $display("FAIL latency_hold t%0d got %h want %h", t,
                         {bout1, diff1, bout8, diff8}, {2'b01, 1'b0, 8'h0F});
            end
            #2;
        end
        after_edge();
        model(8, 1, 16, 0, d, bo);
        n_cmp++;
        if ({bout1, diff1, bout8, diff8} !== {2'b11, bo, d[7:0]}) begin
            n_fail++;
            $display("FAIL latency_update got %h want %h",
                     {bout1, diff1, bout8, diff8}, {2'b11, bo, d[7:0]});
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clock);
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        after_edge();
        n_cmp++;
        if ({bout1, diff1} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_pre got %b%b want 01", bout1, diff1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bout1, diff1} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_async got %b%b want 00", bout1, diff1);
        end
        @(negedge clock);
        rst_n = 1'b1;
        n_cmp++;
        if ({bout1, diff1} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_released got %b%b want 00", bout1, diff1);
        end
        after_edge();
        n_cmp++;
        if ({bout1, diff1} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_after got %b%b want 01", bout1, diff1);
        end
    endtask

    task automatic test_width8_boundaries();
        logic [15:0] vecs [5];
        int   d;
        logic bo;
        vecs[0] = 16'h00FF; vecs[1] = 16'hA525; vecs[2] = 16'h3C3C;
        vecs[3] = 16'hFF00; vecs[4] = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            a8 = vecs[i][15:8]; b8 = vecs[i][7:0]; bin8 = 1'b0;
            model(8, int'(a8), int'(b8), 0, d, bo);
            after_edge();
            n_cmp++;
            if ({bout8, diff8} !== {bo, d[7:0]}) begin
                n_fail++;
                $display("FAIL w8_bound a=%h b=%h got %b/%h want %b/%h",
                         a8, b8, bout8, diff8, bo, d[7:0]);
            end
        end
    endtask

    task automatic test_borrow_in();
`ifdef HALF_SUB_BORROW_IN_EN
        logic [2:0] vecs [3];
        int   d;
        logic bo;
        vecs[0] = 3'b001; vecs[1] = 3'b101; vecs[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            a1 = vecs[i][2]; b1 = vecs[i][1]; bin1 = vecs[i][0];
            model(1, int'(a1), int'(b1), int'(bin1), d, bo);
            after_edge();
            n_cmp++;
            if ({bout1, diff1} !== {bo, d[0]}) begin
                n_fail++;
                $display("FAIL bin a=%b b=%b bin=%b got %b%b want %b%b",
                         a1, b1, bin1, bout1, diff1, bo, d[0]);
            end
        end
        @(negedge clock);
        a8 = 8'h00; b8 = 8'h00; bin8 = 1'b1;
        after_edge();
        n_cmp++;
        if ({bout8, diff8} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL bin_w8_wrap got %b/%h want 1/ff", bout8, diff8);
        end
        bin1 = 1'b0; bin8 = 1'b0;
`endif
    endtask

    task automatic test_random();
        int   d1, d8;
        logic bo1, bo8;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            a1   = 1'($urandom);
            b1   = 1'($urandom);
            bin1 = 1'($urandom);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            bin8 = 1'($urandom);
            model(1, int'(a1), int'(b1), eff_bin(bin1), d1, bo1);
            model(8, int'(a8), int'(b8), eff_bin(bin8), d8, bo8);
            after_edge();
            n_cmp++;
            if ({bout1, diff1, bout8, diff8} !== {bo1, d1[0], bo8, d8[7:0]}) begin
                n_fail++;
                $display("FAIL random[%0d] a1=%b b1=%b a8=%h b8=%h got %b%b %b/%h want %b%b %b/%h",
                         i, a1, b1, a8, b8, bout1, diff1, bout8, diff8,
                         bo1, d1[0], bo8, d8[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_latency();
        test_reset_midstream();
        test_width8_boundaries();
        test_borrow_in();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
